// File: rtl/approx_prod_accumulator.sv
`timescale 1ns/1ps
// approx_prod_accumulator
// Accumulates the unsigned product stream of the approximate 8x8 multiplier
// into saturating frame sums. A frame closes after LEN products or on an
// accepted prod_last. The result is held on sum_* until it is handshaken.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   prod_valid/prod_ready   product input handshake
//   prod_data               unsigned product (PROD_W)
//   prod_last               early frame close, qualified by the handshake
//   clr                     synchronous abort of the frame being accumulated
//   sum_valid/sum_ready     result handshake; result held until accepted
//   sum_data                saturated frame sum (ACC_W)
//   sum_count               number of products in the frame (CNT_W)
//   sum_sat                 saturation occurred somewhere in the frame
module approx_prod_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN    = 8,
  parameter int unsigned CNT_W  = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic              clr,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_sat
);

  // One extra bit catches the carry out of the accumulator for saturation.
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              run_q, run_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0]  sum_data_q, sum_data_d;
  logic [CNT_W-1:0]  sum_count_q, sum_count_d;
  logic              sum_sat_q, sum_sat_d;

  logic              prod_ready_c;
  logic [SUM_W-1:0]  acc_sum_c;
  logic [ACC_W-1:0]  acc_n_c;
  logic [CNT_W-1:0]  cnt_n_c;
  logic              sat_n_c;

  // Next-state, accumulation and handshake logic.
  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    sum_valid_d  = sum_valid_q;
    sum_data_d   = sum_data_q;
    sum_count_d  = sum_count_q;
    sum_sat_d    = sum_sat_q;
    prod_ready_c = 1'b0;

    // Saturating add of the incoming product.
    acc_sum_c = SUM_W'(acc_q) + SUM_W'(prod_data);
    if (acc_sum_c[ACC_W]) begin
      acc_n_c = '1;
      sat_n_c = 1'b1;
    end else begin
      acc_n_c = acc_sum_c[ACC_W-1:0];
      sat_n_c = sat_q;
    end
    cnt_n_c = cnt_q + CNT_W'(1);

    case (state_q)
      ST_ACCUM: begin
        // run_q holds ready low until the first edge out of reset.
        prod_ready_c = run_q & ~clr;
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (prod_valid && prod_ready_c) begin
          if ((cnt_n_c == CNT_W'(LEN)) || prod_last) begin
            sum_data_d  = acc_n_c;
            sum_count_d = cnt_n_c;
            sum_sat_d   = sat_n_c;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_n_c;
            cnt_d = cnt_n_c;
            sat_d = sat_n_c;
          end
        end
      end
      ST_HOLD: begin
        // clr is ignored here so the pending result survives.
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      run_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
      sum_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_count_q <= sum_count_d;
      sum_sat_q   <= sum_sat_d;
    end
  end

  assign prod_ready = prod_ready_c;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign sum_count  = sum_count_q;
  assign sum_sat    = sum_sat_q;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
`timescale 1ns/1ps
// Bench for approx_prod_accumulator: two instances (ACC_W=24 and ACC_W=18)
// share one stimulus stream and are checked against a frame-level model,
// plus literal expectations for the directed scenarios.
module tb_approx_prod_accumulator;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned LEN    = 8;
  localparam int unsigned CNT_W  = $clog2(LEN + 1);
  localparam logic [63:0] LIM_A  = 64'h00FF_FFFF;
  localparam logic [63:0] LIM_B  = 64'h0003_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prod_valid = 1'b0;
  logic [PROD_W-1:0] prod_data = '0;
  logic prod_last = 1'b0;
  logic clr = 1'b0;
  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b0;
  logic rand_mode = 1'b0;
  logic sum_ready;

  logic ready_a, ready_b, valid_a, valid_b, sat_a, sat_b;
  logic [23:0] data_a;
  logic [17:0] data_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  assign sum_ready = rand_mode ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  approx_prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(ready_a),
    .prod_data(prod_data), .prod_last(prod_last), .clr(clr),
    .sum_valid(valid_a), .sum_ready(sum_ready), .sum_data(data_a),
    .sum_count(cnt_a), .sum_sat(sat_a));

  approx_prod_accumulator #(.PROD_W(16), .ACC_W(18), .LEN(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(ready_b),
    .prod_data(prod_data), .prod_last(prod_last), .clr(clr),
    .sum_valid(valid_b), .sum_ready(sum_ready), .sum_data(data_b),
    .sum_count(cnt_b), .sum_sat(sat_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: products of the open frame, last emitted result.
  int unsigned m_prods[$];
  bit          m_run   = 1'b0;
  bit          m_valid = 1'b0;
  logic [63:0] m_total = '0;
  int          m_cnt   = 0;

  function automatic logic [63:0] sat_to(input logic [63:0] v, input logic [63:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prods.delete();
      m_run   = 1'b0;
      m_valid = 1'b0;
      m_total = '0;
      m_cnt   = 0;
      if (clk == 1'b0 && $time > 0) begin
        chk("rst_ready_a", {63'd0, ready_a}, 64'd0);
        chk("rst_valid_a", {63'd0, valid_a}, 64'd0);
        chk("rst_data_a", {40'd0, data_a}, 64'd0);
        chk("rst_cnt_b", {60'd0, cnt_b}, 64'd0);
        chk("rst_sat_b", {63'd0, sat_b}, 64'd0);
      end
    end else begin
      bit exp_rdy;
      exp_rdy = m_run && !m_valid && !clr;
      chk("m_ready_a", {63'd0, ready_a}, {63'd0, exp_rdy});
      chk("m_ready_b", {63'd0, ready_b}, {63'd0, exp_rdy});
      chk("m_valid_a", {63'd0, valid_a}, {63'd0, m_valid});
      chk("m_valid_b", {63'd0, valid_b}, {63'd0, m_valid});
      chk("m_data_a", {40'd0, data_a}, sat_to(m_total, LIM_A));
      chk("m_data_b", {46'd0, data_b}, sat_to(m_total, LIM_B));
      chk("m_cnt_a", {60'd0, cnt_a}, 64'(m_cnt));
      chk("m_cnt_b", {60'd0, cnt_b}, 64'(m_cnt));
      chk("m_sat_a", {63'd0, sat_a}, {63'd0, (m_total > LIM_A)});
      chk("m_sat_b", {63'd0, sat_b}, {63'd0, (m_total > LIM_B)});
      // Advance the model across the coming rising edge.
      if (m_valid) begin
        if (sum_ready) m_valid = 1'b0;
      end else if (m_run && clr) begin
        m_prods.delete();
      end else if (exp_rdy && prod_valid) begin
        m_prods.push_back(int'(prod_data));
        if (m_prods.size() == LEN || prod_last) begin
          m_total = '0;
          foreach (m_prods[i]) m_total += 64'(m_prods[i]);
          m_cnt   = m_prods.size();
          m_valid = 1'b1;
          m_prods.delete();
        end
      end
      m_run = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input int unsigned d, input bit last);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    prod_valid = 1'b1;
    prod_data  = PROD_W'(d);
    prod_last  = last;
    while (!done) begin
      @(negedge clk);
      if (ready_a) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no prod_ready expected ready within 200 cycles");
        done = 1'b1;
      end
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    prod_data  = '0;
  endtask

  task automatic wait_sum();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!valid_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!valid_a) begin
      n_err++;
      $display("FAIL wait_sum: got sum_valid=0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    int n;
    int unsigned a, b;
    bit lst;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_pre_edge", {63'd0, ready_a}, 64'd0);
    @(negedge clk);
    chk("ready_post_edge", {63'd0, ready_a}, 64'd1);
    @(posedge clk);
    #1;

    // 1: full frame of eight 255*255.
    for (int i = 0; i < 8; i++) send(65025, 1'b0);
    wait_sum();
    chk("t1_data", {40'd0, data_a}, 64'd520200);
    chk("t1_cnt", {60'd0, cnt_a}, 64'd8);
    chk("t1_sat", {63'd0, sat_a}, 64'd0);
    @(posedge clk);
    #1;

    // 2: saturation on the 18-bit instance, then a clean frame.
    for (int i = 0; i < 5; i++) send(65025, i == 4);
    wait_sum();
    chk("t2_data_b", {46'd0, data_b}, 64'h3FFFF);
    chk("t2_cnt_b", {60'd0, cnt_b}, 64'd5);
    chk("t2_sat_b", {63'd0, sat_b}, 64'd1);
    chk("t2_data_a", {40'd0, data_a}, 64'd325125);
    @(posedge clk);
    #1;
    send(1, 1'b0);
    send(2, 1'b1);
    wait_sum();
    chk("t2b_data_b", {46'd0, data_b}, 64'd3);
    chk("t2b_sat_b", {63'd0, sat_b}, 64'd0);
    @(posedge clk);
    #1;

    // 3: early close under backpressure.
    dir_ready = 1'b0;
    send(100, 1'b0);
    send(200, 1'b0);
    send(300, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", {63'd0, valid_a}, 64'd1);
      chk("t3_data", {40'd0, data_a}, 64'd600);
      chk("t3_cnt", {60'd0, cnt_a}, 64'd3);
      chk("t3_ready", {63'd0, ready_a}, 64'd0);
    end
    @(posedge clk);
    #1 dir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_ready_after", {63'd0, ready_a}, 64'd1);
    chk("t3_valid_after", {63'd0, valid_a}, 64'd0);
    @(posedge clk);
    #1;

    // 4: clr mid-frame blocks the product on the same cycle.
    send(1000, 1'b0);
    send(2000, 1'b0);
    clr = 1'b1;
    prod_valid = 1'b1;
    prod_data = 16'd7;
    @(negedge clk);
    chk("t4_clr_ready", {63'd0, ready_a}, 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    prod_valid = 1'b0;
    prod_data = '0;
    for (int i = 0; i < 8; i++) send(10, i == 7);
    wait_sum();
    chk("t4_data", {40'd0, data_a}, 64'd80);
    chk("t4_cnt", {60'd0, cnt_a}, 64'd8);
    @(posedge clk);
    #1;

    // 5: reset pulse mid-frame.
    for (int i = 0; i < 4; i++) send(500, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {63'd0, valid_a}, 64'd0);
    chk("t5_ready", {63'd0, ready_a}, 64'd0);
    chk("t5_data", {40'd0, data_a}, 64'd0);
    chk("t5_cnt", {60'd0, cnt_a}, 64'd0);
    chk("t5_sat", {63'd0, sat_b}, 64'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(1, 1'b0);
    wait_sum();
    chk("t5_post_data", {40'd0, data_a}, 64'd8);
    chk("t5_post_cnt", {60'd0, cnt_a}, 64'd8);
    @(posedge clk);
    #1;

    // 6: random 8x8 products with input gaps and random sum_ready.
    rand_mode = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      n = $urandom_range(1, LEN);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        lst = (i == n - 1) && ((n < int'(LEN)) || ($urandom_range(0, 1) == 1));
        send(a * b, lst);
      end
    end
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_idle", {63'd0, valid_a}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_prod_accumulator.md
Name: approx_prod_accumulator

Overview:
Downstream consumer of the unsigned 8x8 approximate multiplier stage. It takes the 16-bit product stream over a valid/ready handshake and accumulates products into a frame sum. A frame closes after LEN products or on an early prod_last. The sum is presented on a held output handshake for dot-product and error-characterisation benches of the approximate multipliers.

Parameters:
PROD_W, 16, product width; matches multiplier z output.
ACC_W, 24, accumulator and sum width; must be >= PROD_W.
LEN, 8, products per frame; must be >= 1.
CNT_W, $clog2(LEN+1), width of the product counter and sum_count.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
prod_valid  input  1  product present on prod_data.
prod_ready  output  1  block accepts a product this cycle.
prod_data  input  PROD_W  unsigned product from multiplier stage.
prod_last  input  1  closes the frame early; qualified by the prod handshake.
clr  input  1  synchronous frame abort.
sum_valid  output  1  frame result available.
sum_ready  input  1  downstream accepts the result.
sum_data  output  ACC_W  frame sum, saturated.
sum_count  output  CNT_W  number of products in the frame.
sum_sat  output  1  saturation occurred in the frame.

Behaviour:
- Reset is asynchronous and active-low. Clock is clk; reset is rst_n, asynchronous, active-low.
- While rst_n=0, all outputs are 0 (prod_ready=0, sum_valid=0, sum_data=0, sum_count=0, sum_sat=0), the internal accumulator, counter and sticky saturation flag are 0, and state=ACCUM.
- On release of reset, prod_ready=1 from the first clock edge at which rst_n=1.
- States: ACCUM and HOLD.
- ACCUM:
  - prod_ready = ~clr.
  - A product is accepted when prod_valid & prod_ready.
  - On accept: acc_n = acc + zero-extended prod_data. If acc_n > 2^ACC_W-1, acc_n = all ones and sat_n = 1; otherwise sat_n = sat. cnt_n = cnt + 1.
  - If cnt_n == LEN or prod_last=1: on the next edge, sum_data <= acc_n, sum_count <= cnt_n, sum_sat <= sat_n, sum_valid <= 1; clear acc, cnt and sat; go to HOLD.
  - Otherwise, register acc_n, cnt_n and sat_n and stay in ACCUM.
- Latency: sum_valid rises on the edge after the final product is accepted.
- HOLD:
  - prod_ready = 0.
  - sum_data, sum_count and sum_sat are stable while sum_valid=1.
  - When sum_valid & sum_ready: sum_valid <= 0 and go to ACCUM. prod_ready=1 from the following cycle, so there is no accept in the same cycle as the result handshake.
  - sum_data, sum_count and sum_sat keep their last values after the handshake.
- clr:
  - In ACCUM, clr has priority over the prod handshake. prod_ready is forced to 0, and acc, cnt and sat clear on the next edge. No result is emitted.
  - In HOLD, clr is ignored and the pending result is not lost.
- prod_last with cnt_n == LEN is a single frame close, not two.
- Saturating arithmetic only; the accumulator never wraps.
- Mid-frame reset discards the partial frame. The frame after reset starts with cnt=0.
- sum_valid must not drop without sum_ready, and prod_valid is not required to remain asserted.

Test Plan:
1. Full frame: LEN=8, ACC_W=24, eight products of 65025 (255*255), sum_ready=1 -> one cycle after the 8th accept, sum_valid=1, sum_data=520200 (0x07F008), sum_count=8, sum_sat=0.
2. Saturation: ACC_W=18, LEN=8, five products of 65025 with prod_last on the 5th -> sum_data=0x3FFFF, sum_count=5, sum_sat=1. The next frame of 1+2 with prod_last gives sum_data=3, sum_sat=0.
3. Early close and backpressure: products 100, 200, 300 with prod_last on 300; sum_ready held 0 for 5 cycles -> sum_data=600, sum_count=3, all outputs stable and prod_ready=0 for those 5 cycles. After the handshake, prod_ready=1 on the next cycle.
4. clr mid-frame: accept 1000 and 2000, then assert clr for one cycle with prod_valid=1 and prod_data=7 -> prod_ready=0 and 7 is not accepted. Eight subsequent products of 10 give sum_data=80, sum_count=8.
5. Reset mid-frame: accept 4 products of 500, then pulse rst_n low between clock edges -> outputs go to 0 immediately. Eight products of 1 after release give sum_data=8, sum_count=8.
6. End-to-end: drive a random operand pair sequence into the approximate multiplier and feed its z output into this block -> sum_data equals the saturated sum of the multiplier outputs, computed by a reference model, for 1000 frames with random prod_valid and sum_ready gaps.
